regfile_arbiter: RTL
====================

# regfile_arbiter

Shares the 64 x 16-bit dual-read, single-write register file between two requesters: requester 0, the CPU writeback/operand path, and requester 1, the debug/loader port. Requesters use a request/grant handshake. Reads can be granted to both requesters in the same cycle, one on each read port. Writes use the single write port, and when both requesters write in the same cycle the write is awarded round-robin. An optional power-up sequencer zeroes every register, because the register file itself has no reset.

## Interface
Parameters:
- ADDR_W, 6, register address width
- DATA_W, 16, register data width
- DEPTH, 64, number of registers; must equal 2**ADDR_W

Ports:
- Clock  in  1  single system clock, rising edge
- nReset  in  1  asynchronous, active-low reset
- Req0 / Req1  in  1  transaction request, one per requester
- Write0 / Write1  in  1  1 = write, 0 = read
- Addr0 / Addr1  in  ADDR_W  target register
- WData0 / WData1  in  DATA_W  write data
- Gnt0 / Gnt1  out  1  combinational; transaction is accepted at the next rising edge of Clock
- RValid0 / RValid1  out  1  registered; read data valid, one-cycle pulse
- RData0 / RData1  out  DATA_W  registered read data
- Ready  out  1  arbiter is in RUN (clear sweep finished)
- RfAddressA  out  ADDR_W  register file port A address (read/write)
- RfWriteData  out  DATA_W  register file write data
- RfWriteEnable  out  1  register file write strobe
- RfAddressB  out  ADDR_W  register file port B address (read only)
- RfReadDataA / RfReadDataB  in  DATA_W  combinational read data from the register file

## Operation
**States**
- CLEAR, RUN.
- Reset enters CLEAR if REGFILE_CLEAR_EN is defined, otherwise RUN.
- CLEAR drives RfAddressA = clear counter, RfWriteData = 0, RfWriteEnable = 1, and holds both grants at 0.
- The clear counter counts 0..DEPTH-1, then the block moves to RUN. No wrap; the block never returns to CLEAR without a reset.

**Arbitration in RUN** (Reqi low means no grant for i):
- Both requesters read: both granted. Port A serves requester 0, port B serves requester 1.
- One requester writes, the other reads: both granted. The writer goes on port A with RfWriteEnable = 1; the reader goes on port B.
- Both requesters write: only the requester named by the priority pointer is granted; the other sees Gnt low and must hold.
- Only one requester active: it is granted on port A.

**Priority pointer**
- Reset value selects requester 0.
- Flips to the other requester only after a write-write conflict is resolved.

**Read timing**
- A read granted in cycle N returns RData = port data sampled at the edge ending cycle N, with RValid high during cycle N+1.
- A read of the address being written in the same cycle returns the old value.
- Write-then-read on consecutive cycles returns the new value.

**Handshake rules**
- A requester holds Req, Write, Addr and WData stable until its Gnt is seen high.
- Keeping Req high after a grant issues a new transaction.
- Requests made while Ready is low are ignored, not queued.

**Idle port behaviour**
- RfAddressA and RfAddressB are 0 when their port is idle.
- RfWriteEnable is 0 unless a write is granted or the block is in CLEAR.

## Timing
- **Reset values:** Gnt0/1 = 0, RValid0/1 = 0, RData0/1 = 0, RfWriteEnable = 0, RfAddressA/B = 0, pointer = requester 0, clear counter = 0. Ready = 0 with REGFILE_CLEAR_EN, 1 without it.
- **RfWriteEnable during reset:** forced 0 combinationally while nReset is low, including when state is CLEAR.
- **Clear sweep:** with REGFILE_CLEAR_EN, the sweep writes addresses 0..63 over 64 cycles after nReset deasserts. Ready rises in the cycle after address 63 is written.
- **Reset mid-sweep:** asserting nReset during the sweep restarts it from address 0.
- **Reset mid-transaction:** a read granted in the cycle nReset asserts produces no RValid.
- **Latency:** grant in 0 cycles (same cycle as the request); read data in 1 cycle; write visible on the next cycle.
- **Throughput:** 2 transactions per cycle, except a write-write conflict, which gives 1 per cycle.

## Configuration
- REGFILE_CLEAR_EN defined: the CLEAR state and the 6-bit clear counter are compiled in. Every register reads 0 after reset, and Ready stays low for 64 cycles.
- REGFILE_CLEAR_EN undefined: no CLEAR state and no counter. Reset goes straight to RUN with Ready = 1, and register contents are undefined until written.

## Test plan
- **Clear sweep (REGFILE_CLEAR_EN defined):** release nReset, then read all 64 addresses after Ready rises -> Ready rises exactly 64 cycles after release, and every RData = 0x0000.
- **Dual read:** Req0 read addr 5 and Req1 read addr 9 in the same cycle, with reg5 = 0x1234 and reg9 = 0xBEEF -> Gnt0 = Gnt1 = 1; in the next cycle RValid0 = RValid1 = 1, RData0 = 0x1234, RData1 = 0xBEEF.
- **Write-write conflict:** both requesters write addr 3 with 0xAAAA / 0x5555, held for 2 cycles -> cycle 1 grants requester 0 only, cycle 2 grants requester 1; a following read of reg3 returns 0x5555.
- **Read during write:** reg7 = 0x0001; Req0 writes 0x00FF to addr 7 while Req1 reads addr 7 -> RData1 = 0x0001; a Req1 read of addr 7 on the next cycle returns 0x00FF.
- **Reset mid-sweep:** assert nReset at clear address 40, then release -> the sweep restarts at 0 and Ready rises 64 cycles after the release.
- **Requests before Ready:** Req0 read asserted while Ready = 0 -> Gnt0 stays 0, no RValid0, and RfWriteEnable stays driven by the sweep only.

Source files
------------

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter for a 2R/1W register file; REGFILE_CLEAR_EN adds a power-up zeroing sweep
module regfile_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Write0,
  input  logic              Write1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              Ready,
  output logic [ADDR_W-1:0] RfAddressA,
  output logic [DATA_W-1:0] RfWriteData,
  output logic              RfWriteEnable,
  output logic [ADDR_W-1:0] RfAddressB,
  input  logic [DATA_W-1:0] RfReadDataA,
  input  logic [DATA_W-1:0] RfReadDataB
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [ADDR_W-1:0] cnt;
  logic ptr, r0, r1, ww, a1;
  if (DEPTH != 2 ** ADDR_W) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_W");
  end
`ifdef REGFILE_CLEAR_EN
  state_t next;
  // state register and sweep address counter
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= next;
      cnt   <= (state == CLEAR) ? cnt + 1'b1 : cnt;
    end
  // leave CLEAR once the last address has been written
  always_comb next = (state == CLEAR && cnt == ADDR_W'(DEPTH - 1)) ? RUN : state;
`else
  assign state = RUN;
  assign cnt   = '0;
`endif
  assign Ready = state == RUN;
  // grants and register-file port steering; writer always owns port A
  always_comb begin
    r0            = Req0 & Ready;
    r1            = Req1 & Ready;
    ww            = r0 & r1 & Write0 & Write1;
    Gnt0          = r0 & ~(ww & ptr);
    Gnt1          = r1 & ~(ww & ~ptr);
    a1            = Gnt1 & (~Gnt0 | Write1);
    RfAddressA    = !Ready ? cnt : (Gnt0 | Gnt1) ? (a1 ? Addr1 : Addr0) : '0;
    RfAddressB    = (Gnt0 & Gnt1) ? (a1 ? Addr0 : Addr1) : '0;
    RfWriteData   = !Ready ? '0 : a1 ? WData1 : WData0;
    RfWriteEnable = nReset & (!Ready | (a1 ? Write1 : Gnt0 & Write0));
  end
  // pointer flips on each resolved write-write conflict; reads return data one cycle later
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      ptr     <= 1'b0;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      RData0  <= '0;
      RData1  <= '0;
    end else begin
      ptr     <= ptr ^ ww;
      RValid0 <= Gnt0 & ~Write0;
      RValid1 <= Gnt1 & ~Write1;
      if (Gnt0 & ~Write0) RData0 <= a1 ? RfReadDataB : RfReadDataA;
      if (Gnt1 & ~Write1) RData1 <= a1 ? RfReadDataA : RfReadDataB;
    end
endmodule
